// File: rtl/button_debounce.sv
// Two-flop synchroniser, per-button stability-counter debouncer, press/release strobes and sticky event flags.
// Optional macro BTN_DEBOUNCE_RELEASE_EVT_EN: release strobes also set event_pending.
module button_debounce #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [N_BTN-1:0] event_pending,
  input  logic [N_BTN-1:0] event_clr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] evt_set;

  // s1 may go metastable; only s2 is consumed past this point.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // NOTE: the counter array is reset too, so a reset mid-count discards any partial count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_clean <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      btn_rise <= '0;
      btn_fall <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == btn_clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          btn_clean[i] <= s2[i];
          btn_rise[i]  <= s2[i];
          btn_fall[i]  <= ~s2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef BTN_DEBOUNCE_RELEASE_EVT_EN
  assign evt_set = btn_rise | btn_fall;
`else
  assign evt_set = btn_rise;
`endif

  // Set has priority over a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) event_pending <= '0;
    else      event_pending <= (event_pending & ~event_clr) | evt_set;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (DEBOUNCE_CYCLES=4, N_BTN=4): directed scenarios plus
// randomized stimulus checked against a sliding-window behavioural model.
module tb_button_debounce;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] event_clr = '0;
  logic [N-1:0] btn_clean, btn_rise, btn_fall, event_pending;

  int n_checks = 0;
  int n_errors = 0;

  button_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_clean(btn_clean),
    .btn_rise(btn_rise), .btn_fall(btn_fall), .event_pending(event_pending),
    .event_clr(event_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a button flips once the last D synchronised samples taken
  // since its previous flip (or reset) all disagree with its clean level.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_fall = '0, m_pend = '0;
  logic [N-1:0] n_clean, n_rise, n_fall, m_evt;
  logic [N-1:0] hist [$];
  int           age [N];
  bit           all_diff;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_pend = '0;
      hist.delete();
      for (int i = 0; i < N; i++) age[i] = 0;
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      n_clean = m_clean; n_rise = '0; n_fall = '0;
      for (int i = 0; i < N; i++) begin
        age[i]++;
        if (age[i] >= D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (hist[j][i] == m_clean[i]) all_diff = 1'b0;
          if (all_diff) begin
            n_clean[i] = ~m_clean[i];
            n_rise[i]  = n_clean[i];
            n_fall[i]  = ~n_clean[i];
            age[i]     = 0;
          end
        end
      end
`ifdef BTN_DEBOUNCE_RELEASE_EVT_EN
      m_evt = m_rise | m_fall;
`else
      m_evt = m_rise;
`endif
      m_pend  = (m_pend & ~event_clr) | m_evt;
      m_clean = n_clean; m_rise = n_rise; m_fall = n_fall;
      m_s2 = m_s1; m_s1 = btn_raw;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; btn_raw = '0; event_clr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; btn_raw = 4'hF; event_clr = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_clean, btn_rise, btn_fall, event_pending} !== 16'h0) begin
        n_errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0000", c, {btn_clean, btn_rise, btn_fall, event_pending});
      end
    end
    rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_clean, btn_rise, event_pending} !==
          {(j >= 5) ? 4'hF : 4'h0, (j == 5) ? 4'hF : 4'h0, (j >= 6) ? 4'hF : 4'h0}) begin
        n_errors++;
        $display("FAIL reset_release j=%0d clean/rise/pend got=%h", j, {btn_clean, btn_rise, event_pending});
      end
    end
  endtask

  task automatic test_reset_midcount();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({btn_clean, btn_rise, btn_fall, event_pending} !== 16'h0) begin
      n_errors++;
      $display("FAIL async_reset got=%h exp=0000", {btn_clean, btn_rise, btn_fall, event_pending});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_clean, btn_rise} !== {(j >= 5) ? 4'hF : 4'h0, (j == 5) ? 4'hF : 4'h0}) begin
        n_errors++;
        $display("FAIL midcount_reset j=%0d clean/rise got=%h", j, {btn_clean, btn_rise});
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    btn_raw[0] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 2) btn_raw[0] = 1'b0;
      n_checks++;
      if ({btn_clean, btn_rise, btn_fall, event_pending} !== 16'h0) begin
        n_errors++;
        $display("FAIL glitch cyc=%0d got=%h exp=0000", c, {btn_clean, btn_rise, btn_fall, event_pending});
      end
    end
  endtask

  task automatic test_press_release();
    do_reset();
    btn_raw[2] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_clean, btn_rise, btn_fall, event_pending} !==
          {(j >= 5) ? 4'h4 : 4'h0, (j == 5) ? 4'h4 : 4'h0, 4'h0, (j >= 6) ? 4'h4 : 4'h0}) begin
        n_errors++;
        $display("FAIL press j=%0d got=%h", j, {btn_clean, btn_rise, btn_fall, event_pending});
      end
    end
    btn_raw[2] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_clean, btn_rise, btn_fall} !== {(j >= 5) ? 4'h0 : 4'h4, 4'h0, (j == 5) ? 4'h4 : 4'h0}) begin
        n_errors++;
        $display("FAIL release j=%0d got=%h", j, {btn_clean, btn_rise, btn_fall});
      end
    end
  endtask

  task automatic test_bounce();
    logic [9:0] seq = 10'b1111101101; // bit i is the level applied in cycle i
    do_reset();
    btn_raw[1] = seq[0];
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_clean[1], btn_rise[1]} !== {j >= 10, j == 10}) begin
        n_errors++;
        $display("FAIL bounce j=%0d clean=%b rise=%b exp=%b%b", j, btn_clean[1], btn_rise[1], j >= 10, j == 10);
      end
      btn_raw[1] = (j + 1 < 10) ? seq[j + 1] : 1'b1;
    end
  endtask

  task automatic test_collision();
    do_reset();
    btn_raw[3] = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (btn_rise[3] !== 1'b1) begin
      n_errors++;
      $display("FAIL collision_rise got=%b exp=1", btn_rise[3]);
    end
    event_clr[3] = 1'b1;
    @(negedge clk);
    event_clr[3] = 1'b0;
    n_checks++;
    if (event_pending[3] !== 1'b1) begin
      n_errors++;
      $display("FAIL collision_set_wins got=%b exp=1", event_pending[3]);
    end
    @(negedge clk);
    n_checks++;
    if (event_pending[3] !== 1'b1) begin
      n_errors++;
      $display("FAIL collision_hold got=%b exp=1", event_pending[3]);
    end
    event_clr[3] = 1'b1;
    @(negedge clk);
    event_clr[3] = 1'b0;
    n_checks++;
    if (event_pending[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL collision_clear got=%b exp=0", event_pending[3]);
    end
  endtask

  task automatic test_macro();
    logic exp_pend;
`ifdef BTN_DEBOUNCE_RELEASE_EVT_EN
    exp_pend = 1'b1;
`else
    exp_pend = 1'b0;
`endif
    do_reset();
    btn_raw[0] = 1'b1;
    repeat (8) @(negedge clk);
    event_clr[0] = 1'b1;
    @(negedge clk);
    event_clr[0] = 1'b0;
    n_checks++;
    if (event_pending[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL macro_preclear got=%b exp=0", event_pending[0]);
    end
    btn_raw[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_clean[0], btn_fall[0]} !== {j < 5, j == 5}) begin
        n_errors++;
        $display("FAIL macro_release j=%0d clean=%b fall=%b", j, btn_clean[0], btn_fall[0]);
      end
    end
    n_checks++;
    if (event_pending[0] !== exp_pend) begin
      n_errors++;
      $display("FAIL macro_release_event got=%b exp=%b", event_pending[0], exp_pend);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_clean, btn_rise, btn_fall, event_pending} !== {m_clean, m_rise, m_fall, m_pend}) begin
        n_errors++;
        $display("FAIL random cyc=%0d clean/rise/fall/pend got=%h exp=%h", c,
                 {btn_clean, btn_rise, btn_fall, event_pending}, {m_clean, m_rise, m_fall, m_pend});
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
        event_clr[i] = ($urandom_range(0, 7) == 0);
      end
    end
    event_clr = '0;
  endtask

  initial begin
    #1 rst = 1'b0;
    test_reset();
    test_reset_midcount();
    test_glitch();
    test_press_release();
    test_bounce();
    test_collision();
    test_macro();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Input-conditioning stage that sits directly upstream of the Wishbone button GPIO slave. It synchronises the raw push-button pins into `clk`, debounces each button with an independent stability counter, and drives the clean levels that the GPIO block presents on the bus. It also produces one-cycle press and release strobes and sticky per-button event flags. These let firmware poll for presses instead of sampling levels.

## Interface

Parameters:
- `N_BTN`, 4, number of buttons.
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz). Legal range: at least 2 and below 2^`CNT_W`.
- `CNT_W`, 20, width of each per-button stability counter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  `N_BTN`  raw button pins, asynchronous to `clk`, active-high.
- `btn_clean`  out  `N_BTN`  debounced levels, fed to the GPIO block's lower bits.
- `btn_rise`  out  `N_BTN`  one-cycle strobe when a clean 0→1 is accepted.
- `btn_fall`  out  `N_BTN`  one-cycle strobe when a clean 1→0 is accepted.
- `event_pending`  out  `N_BTN`  sticky event flags.
- `event_clr`  in  `N_BTN`  per-bit clear of `event_pending`, level-sensitive.

## Operation

- **Synchroniser:** two-flop chain per bit, `btn_raw` → `s1` → `s2`. `s2` is the only value consumed downstream of the chain.
- **Per-button counter `cnt[i]`:**
  - If `s2[i] == btn_clean[i]`: `cnt[i] <= 0`. Any glitch restarts the count.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`:
    - `btn_clean[i] <= s2[i]` and `cnt[i] <= 0`.
    - Strobe `btn_rise[i]` if the new level is 1, otherwise `btn_fall[i]`.
  - Else: `cnt[i] <= cnt[i] + 1`.
- **Counter range:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.
- **Event flags:** `event_pending[i]` is set by `btn_rise[i]` (see Configuration) and cleared by `event_clr[i]`. When set and clear occur in the same cycle, set wins.
- **Independence:** buttons are fully independent. Simultaneous transitions on several bits are each accepted on their own schedule.

## Timing

- **Reset values:** while `rst` is low, all of the following are 0: `s1`, `s2`, `cnt`, `btn_clean`, `btn_rise`, `btn_fall`, `event_pending`. Reset takes effect immediately (asynchronous). Release is synchronous to the first `clk` edge.
- **Latency:** let edge k be the first edge at which `s1` samples a new, stable raw level.
  - `s2` takes the new level at edge k+1.
  - `cnt` counts 0→1 at edge k+2.
  - `btn_clean` changes at edge k+`DEBOUNCE_CYCLES`+1.
- **Strobes:** `btn_rise` / `btn_fall` are registered. They are high for exactly the one cycle in which `btn_clean` first shows the new level.
- **Event flag:** `event_pending` rises one cycle after the `btn_rise` strobe. It falls one cycle after the `event_clr` sample, unless a set occurs in that same cycle.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` never changes `btn_clean` and produces no strobe.
- **Reset mid-count:** asserting `rst` mid-count discards the partial count. After release, a held-high button needs a full `DEBOUNCE_CYCLES`+2 cycles to be accepted, and then produces `btn_rise`.
- **Combinational paths:** none. All outputs are registered, with no combinational path from any input to any output.

## Configuration

- **Macro:** `BTN_DEBOUNCE_RELEASE_EVT_EN`.
- **Defined:** `event_pending[i]` is set by either `btn_rise[i]` or `btn_fall[i]`. Firmware sees both press and release events.
- **Undefined:** `event_pending[i]` is set by `btn_rise[i]` only. `btn_fall` is still generated and output unchanged.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4`, `N_BTN=4`.

1. **Reset:** hold `rst`=0 with `btn_raw`=4'hF. All outputs read 0 throughout. After release with `btn_raw` held at 4'hF, `btn_clean` becomes 4'hF at edge k+5, `btn_rise`=4'hF for one cycle, and `event_pending`=4'hF on the next cycle.
2. **Glitch rejection:** pulse `btn_raw[0]` high for 3 cycles, then low. `btn_clean` stays 4'h0, no strobes occur, and `event_pending` stays 4'h0.
3. **Clean press and release:** raise `btn_raw[2]` and hold for 10 cycles. `btn_clean[2]` rises exactly 5 edges after the first sampling edge, with a single `btn_rise[2]` pulse. Then drop it: `btn_clean[2]` falls 5 edges later with a single `btn_fall[2]` pulse.
4. **Bouncing press:** apply `btn_raw[1]` = 1,0,1,1,0,1,1,1,1,1. `btn_clean[1]` rises only after 4 consecutive stable cycles at `s2`, with exactly one `btn_rise[1]` pulse.
5. **Set/clear collision:** hold `event_clr[3]`=1 in the cycle `btn_rise[3]` pulses. `event_pending[3]`=1 afterwards. A later clear-only cycle returns it to 0.
6. **Macro check:** with `BTN_DEBOUNCE_RELEASE_EVT_EN` defined, a release of button 0 sets `event_pending[0]`. Without the macro, the same release leaves `event_pending[0]`=0 while `btn_fall[0]` still pulses.
